// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial frame transmitter: state encoding,
// line levels and a counter-width helper.
package serial_tx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    // A counter over n values needs at least one bit, even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_baud_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period.
(* block_name = "serial_tx_baud_gen", block_version = "1.0" *)
module serial_tx_baud_gen
    import serial_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    (* port_role = "clock" *)  input  logic clk,
    (* port_role = "reset" *)  input  logic rst,
    (* port_role = "enable" *) input  logic en,
    (* port_role = "tick" *)   output logic tick
);

    localparam int CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    (* net_role = "baud_counter" *)
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (!en || (count == CNT_LAST)) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = en && (count == CNT_LAST);

endmodule

// File: rtl/serial_tx.sv
// Bit-serial frame transmitter: start bit, data LSB first, optional even
// parity, stop bit. Words arrive over a valid/ready handshake.
(* block_name = "serial_tx", block_version = "1.0" *)
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    (* port_role = "clock" *)        input  logic                  clk,
    (* port_role = "reset" *)        input  logic                  rst,
    (* port_role = "word" *)         input  logic [DATA_WIDTH-1:0] tx_data,
    (* port_role = "word_valid" *)   input  logic                  tx_valid,
    (* port_role = "word_ready" *)   output logic                  tx_ready,
    (* port_role = "serial_line" *)  output logic                  tx_out,
    (* port_role = "busy" *)         output logic                  tx_busy,
    (* port_role = "frame_done" *)   output logic                  tx_done
);

    localparam int BIT_W = cnt_width(DATA_WIDTH);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    (* net_role = "fsm_state" *)
    tx_state_t state;
    (* net_role = "fsm_state_next" *)
    tx_state_t state_next;
    (* net_role = "bit_index" *)
    logic [BIT_W-1:0] bit_idx;
    (* net_role = "shift_register" *)
    logic [DATA_WIDTH-1:0] shift_reg;
    (* net_role = "parity_bit" *)
    logic parity_bit;

    logic                  tick;
    logic                  accept;
    logic [DATA_WIDTH-1:0] shift_shr;
    logic                  tx_out_next;
    logic                  tx_done_next;

    assign tx_ready  = (state == IDLE);
    assign tx_busy   = (state != IDLE);
    assign accept    = tx_valid && tx_ready;
    assign shift_shr = shift_reg >> 1;

    (* inst_role = "bit_timer" *)
    serial_tx_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (tx_busy),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (tick) state_next = DATA;
            DATA: begin
                if (tick && (bit_idx == BIT_LAST)) begin
                    state_next = (PARITY_EN != 0) ? PARITY : STOP;
                end
            end
            PARITY:  if (tick) state_next = STOP;
            STOP:    if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The line is registered, so its next value is derived from where the
    // FSM and shift register are headed rather than where they are.
    always_comb begin
        tx_out_next  = LINE_IDLE;
        tx_done_next = 1'b0;
        case (state_next)
            START:   tx_out_next = LINE_START;
            DATA:    tx_out_next = (state == DATA && tick) ? shift_shr[0] : shift_reg[0];
            PARITY:  tx_out_next = parity_bit;
            default: tx_out_next = LINE_IDLE;
        endcase
        if ((state == STOP) && (state_next == IDLE)) begin
            tx_done_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            bit_idx    <= '0;
            parity_bit <= 1'b0;
        end else if (accept) begin
            shift_reg  <= tx_data;
            bit_idx    <= '0;
            parity_bit <= ^tx_data;
        end else if ((state == DATA) && tick) begin
            shift_reg <= shift_shr;
            bit_idx   <= (bit_idx == BIT_LAST) ? '0 : bit_idx + BIT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_out  <= LINE_IDLE;
            tx_done <= 1'b0;
        end else begin
            tx_out  <= tx_out_next;
            tx_done <= tx_done_next;
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Scoreboard bench for serial_tx: three configurations (default, no parity,
// 1-bit word at one clock per bit) each watched by its own frame monitor.
module tb_serial_tx;

    typedef struct {
        logic [15:0] bits;
        int          nslots;
    } frame_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid [3];
    logic [7:0] data  [3];
    logic       ready [3];
    logic       line  [3];
    logic       busy  [3];
    logic       done  [3];

    frame_t exp_q [3][$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    function automatic int dw_of(input int g);
        return (g == 2) ? 1 : 8;
    endfunction

    function automatic int pe_of(input int g);
        return (g == 1) ? 0 : 1;
    endfunction

    task automatic chk(input bit ok, input string name, input int act, input int expv);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Expected line level per bit slot: start, data LSB first, parity, stop.
    function automatic frame_t mk_frame(input logic [7:0] d, input int dw, input int pe);
        frame_t f;
        int     s;
        logic   p;
        f.bits = '1;
        p      = 1'b0;
        s      = 0;
        f.bits[s] = 1'b0;
        s++;
        for (int i = 0; i < dw; i++) begin
            f.bits[s] = d[i];
            p         = p ^ d[i];
            s++;
        end
        if (pe != 0) begin
            f.bits[s] = p;
            s++;
        end
        f.bits[s] = 1'b1;
        s++;
        f.nslots = s;
        return f;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int DW  = (g == 2) ? 1 : 8;
        localparam int CPB = (g == 2) ? 1 : 4;
        localparam int PE  = (g == 1) ? 0 : 1;

        serial_tx #(
            .DATA_WIDTH  (DW),
            .CLKS_PER_BIT(CPB),
            .PARITY_EN   (PE)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .tx_data  (data[g][DW-1:0]),
            .tx_valid (valid[g]),
            .tx_ready (ready[g]),
            .tx_out   (line[g]),
            .tx_busy  (busy[g]),
            .tx_done  (done[g])
        );

        frame_t cur;
        bit     in_frame = 1'b0;
        bit     ended    = 1'b0;
        int     cyc      = 0;

        always @(negedge clk) begin
            if (rst) begin
                in_frame = 1'b0;
                ended    = 1'b0;
            end else begin
                ended = 1'b0;
                if (busy[g] && !in_frame) begin
                    chk(exp_q[g].size() != 0, "frame_expected", exp_q[g].size(), 1);
                    if (exp_q[g].size() != 0) cur = exp_q[g].pop_front();
                    else cur = mk_frame(8'h00, DW, PE);
                    in_frame = 1'b1;
                    cyc      = 0;
                end
                if (in_frame) begin
                    if (busy[g]) begin
                        int   slot;
                        logic e;
                        slot = cyc / CPB;
                        e    = (slot < cur.nslots && slot < 16) ? cur.bits[slot] : 1'b1;
                        chk(line[g] == e, $sformatf("line[%0d] slot %0d", g, slot), int'(line[g]), int'(e));
                        chk(ready[g] == 1'b0, $sformatf("ready_busy[%0d]", g), int'(ready[g]), 0);
                        chk(done[g] == 1'b0, $sformatf("done_busy[%0d]", g), int'(done[g]), 0);
                        cyc++;
                    end else begin
                        chk(done[g] == 1'b1, $sformatf("done_end[%0d]", g), int'(done[g]), 1);
                        chk(ready[g] == 1'b1, $sformatf("ready_end[%0d]", g), int'(ready[g]), 1);
                        chk(cyc == cur.nslots * CPB, $sformatf("frame_len[%0d]", g), cyc, cur.nslots * CPB);
                        chk(line[g] == 1'b1, $sformatf("line_end[%0d]", g), int'(line[g]), 1);
                        in_frame = 1'b0;
                        ended    = 1'b1;
                    end
                end else if (!busy[g]) begin
                    chk(done[g] == 1'b0, $sformatf("done_idle[%0d]", g), int'(done[g]), 0);
                    chk(line[g] == 1'b1, $sformatf("line_idle[%0d]", g), int'(line[g]), 1);
                end
            end
        end
    end

    // Present a word and wait for acceptance; returns just after the
    // acceptance edge, leaving tx_valid high. The word is then scrambled to
    // show that the frame in flight ignores later tx_data changes.
    task automatic send(input int g, input logic [7:0] d, input bit b2b);
        int t;
        t = 0;
        valid[g] = 1'b1;
        data[g]  = d;
        exp_q[g].push_back(mk_frame(d, dw_of(g), pe_of(g)));
        while (!ready[g] && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) begin
            chk(1'b0, "ready_timeout", t, 500);
        end
        if (b2b) chk(done[g] == 1'b1, "b2b_accept_in_done_cycle", int'(done[g]), 1);
        @(posedge clk);
        #1;
        chk(busy[g] == 1'b1, "busy_after_accept", int'(busy[g]), 1);
        if (b2b) chk(line[g] == 1'b0, "b2b_start_bit", int'(line[g]), 0);
        data[g] = ~d;
    endtask

    task automatic wait_idle(input int g);
        int t;
        t = 0;
        @(negedge clk);
        while ((busy[g] || done[g] || exp_q[g].size() != 0) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk(t < 500, "idle_timeout", t, 500);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            valid[i] = 1'b0;
            data[i]  = 8'h00;
        end

        // Reset held with a pending word: nothing may start.
        valid[0] = 1'b1;
        data[0]  = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(line[0] == 1'b1, "rst_line", int'(line[0]), 1);
            chk(ready[0] == 1'b1, "rst_ready", int'(ready[0]), 1);
            chk(busy[0] == 1'b0, "rst_busy", int'(busy[0]), 0);
            chk(done[0] == 1'b0, "rst_done", int'(done[0]), 0);
        end
        exp_q[0].push_back(mk_frame(8'h5A, 8, 1));
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk(busy[0] == 1'b1, "start_after_release", int'(busy[0]), 1);
        chk(line[0] == 1'b0, "start_bit_after_release", int'(line[0]), 0);
        valid[0] = 1'b0;
        wait_idle(0);

        // 0xA5: line 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1, 44 busy cycles.
        send(0, 8'hA5, 1'b0);
        valid[0] = 1'b0;
        wait_idle(0);

        // 0x07: three ones, parity bit 1.
        send(0, 8'h07, 1'b0);
        valid[0] = 1'b0;
        wait_idle(0);

        // No parity slot: 40-cycle frame.
        send(1, 8'hA5, 1'b0);
        valid[1] = 1'b0;
        wait_idle(1);

        // One data bit, one clock per bit: 0,1,1(parity),1(stop).
        send(2, 8'h01, 1'b0);
        valid[2] = 1'b0;
        wait_idle(2);
        send(2, 8'h00, 1'b0);
        valid[2] = 1'b0;
        wait_idle(2);

        // Back-to-back with tx_valid held.
        send(0, 8'h3C, 1'b0);
        send(0, 8'hC3, 1'b1);
        valid[0] = 1'b0;
        wait_idle(0);

        // Reset during data bit 3 of 0xFF (cycles 17..20 after acceptance).
        send(0, 8'hFF, 1'b0);
        valid[0] = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk(line[0] == 1'b1, "midrst_line", int'(line[0]), 1);
        chk(busy[0] == 1'b0, "midrst_busy", int'(busy[0]), 0);
        chk(ready[0] == 1'b1, "midrst_ready", int'(ready[0]), 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(0, 8'h00, 1'b0);
        valid[0] = 1'b0;
        wait_idle(0);

        for (int i = 0; i < 3; i++) begin
            chk(exp_q[i].size() == 0, "queue_drained", exp_q[i].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
